// File: rtl/qrisc32_avm_arbiter_pkg.sv
// ============================================================================
// risc_pack : shared types and constants for the qrisc32 Avalon-MM arbiter
// Revision  : 1.0
// ============================================================================
`default_nettype none

package risc_pack;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

endpackage

`default_nettype wire

// File: rtl/qrisc32_avm_arbiter_rr_picker.sv
// ============================================================================
// qrisc32_rr_picker : combinational one-hot winner search from a start pointer
// Revision          : 1.0
// ============================================================================
`default_nettype none

module qrisc32_rr_picker #(
  parameter int N     = 3,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_start,
  input  logic             i_wrap,
  output logic [N-1:0]     o_grant
);

  // Walk N slots upward from i_start; without wrap, slots past N-1 are skipped.
  always_comb begin : p_pick
    int  w_idx;
    logic w_found;
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = int'(i_start) + i;
      if (w_idx >= N) begin
        w_idx = i_wrap ? (w_idx - N) : -1;
      end
      if (!w_found && (w_idx >= 0) && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/qrisc32_avm_arbiter.sv
// ============================================================================
// qrisc32_avm_arbiter : N-channel Avalon-MM master arbiter, one transfer/grant
// Revision            : 1.0
// ============================================================================
`default_nettype none

module qrisc32_avm_arbiter
  import risc_pack::*;
#(
  parameter int NUM_CH   = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MODE     = ARB_RR,
  parameter int MAX_WAIT = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr,
  input  logic [NUM_CH-1:0]              ch_rd,
  input  logic [NUM_CH-1:0]              ch_wr,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_wdata,
  output logic [NUM_CH-1:0][DATA_W-1:0]  ch_rdata,
  output logic [NUM_CH-1:0]              ch_wait_req,
  output logic [ADDR_W-1:0]              avm_addr,
  output logic [DATA_W-1:0]              avm_wdata,
  output logic                           avm_rd,
  output logic                           avm_wr,
  input  logic [DATA_W-1:0]              avm_rdata,
  input  logic                           avm_wait_req,
  output logic [NUM_CH-1:0]              grant,
  output logic                           timeout
);

  localparam int               PTR_W      = $clog2(NUM_CH);
  localparam int               CNT_W      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic             c_TO_EN    = (MAX_WAIT != 0);
  localparam logic [PTR_W-1:0] c_LAST_RST = PTR_W'(NUM_CH - 1);
  localparam logic             c_RR       = (MODE != ARB_FIXED);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [NUM_CH-1:0] r_grant;
  logic [PTR_W-1:0]  r_gidx;
  logic [PTR_W-1:0]  r_last;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [DATA_W-1:0] r_wdata_hold;

  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_pick;
  logic [PTR_W-1:0]  w_pick_idx;
  logic [PTR_W-1:0]  w_start;
  logic              w_busy;
  logic              w_own_req;
  logic              w_abort;

  assign w_req     = ch_rd | ch_wr;
  assign w_busy    = (r_state == ARB_BUSY);
  assign w_own_req = w_req[r_gidx];
  // A withdrawn request never counts as a timeout.
  assign w_abort   = w_busy & w_own_req & c_TO_EN & (r_cnt == c_CNT_MAX);
  assign w_start   = !c_RR ? '0 :
                     (r_last == c_LAST_RST) ? '0 : (r_last + PTR_W'(1));

  qrisc32_rr_picker #(
    .N     (NUM_CH),
    .PTR_W (PTR_W)
  ) u_picker (
    .i_req   (w_req),
    .i_start (w_start),
    .i_wrap  (c_RR),
    .o_grant (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_pick[i]) w_pick_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ARB_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: if (|w_req) w_next = ARB_BUSY;
      ARB_BUSY: if (!w_own_req || w_abort || !avm_wait_req) w_next = ARB_IDLE;
      default:  w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant      <= '0;
      r_gidx       <= '0;
      r_last       <= c_LAST_RST;
      r_cnt        <= '0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else if (!w_busy) begin
      if (|w_req) begin
        r_grant <= w_pick;
        r_gidx  <= w_pick_idx;
        r_cnt   <= '0;
        if (c_RR) r_last <= w_pick_idx;
      end
    end else begin
      // Shadow the live bus so an idle bus keeps showing the last transfer.
      r_addr_hold  <= ch_addr[r_gidx];
      r_wdata_hold <= ch_wdata[r_gidx];
      if (w_next == ARB_IDLE)          r_grant <= '0;
      else if (avm_wait_req && c_TO_EN) r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    ch_rdata    = {NUM_CH{avm_rdata}};
    ch_wait_req = '1;
    avm_addr    = r_addr_hold;
    avm_wdata   = r_wdata_hold;
    avm_rd      = 1'b0;
    avm_wr      = 1'b0;
    grant       = r_grant;
    timeout     = w_abort;
    if (w_busy) begin
      avm_addr            = ch_addr[r_gidx];
      avm_wdata           = ch_wdata[r_gidx];
      avm_rd              = ch_rd[r_gidx] & ~w_abort;
      avm_wr              = ch_wr[r_gidx] & ~w_abort;
      ch_wait_req[r_gidx] = w_abort ? 1'b0 : avm_wait_req;
      if (w_abort) ch_rdata[r_gidx] = '0;
    end
  end

endmodule

`default_nettype wire

// File: doc/qrisc32_avm_arbiter.md
# qrisc32_avm_arbiter

Parametrised N-channel Avalon-MM master arbiter. It merges the core's separate Avalon master ports (instruction read, data read, data write, plus future DMA/debug masters) onto one shared Avalon bus towards a single memory. Each channel is a standard Avalon master-side port with `wait_req` back-pressure. The arbiter selects round-robin or fixed priority, holds the grant for exactly one transfer, and aborts transfers that stall past a timeout.

## Interface
- `NUM_CH`, 3: number of upstream channels (2..8).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MODE`, `ARB_RR`: `ARB_RR` = round robin; `ARB_FIXED` = channel 0 highest priority.
- `MAX_WAIT`, 255: downstream stall cycles before abort; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all state on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `ch_addr` in [NUM_CH][ADDR_W]: per-channel address.
- `ch_rd` in [NUM_CH]: per-channel read request.
- `ch_wr` in [NUM_CH]: per-channel write request.
- `ch_wdata` in [NUM_CH][DATA_W]: per-channel write data.
- `ch_rdata` out [NUM_CH][DATA_W]: read data; valid when that channel's `ch_wait_req`=0 and its `ch_rd`=1.
- `ch_wait_req` out [NUM_CH]: per-channel stall.
- `avm_addr`, `avm_wdata` out ADDR_W/DATA_W: downstream address and write data.
- `avm_rd`, `avm_wr` out 1: downstream strobes.
- `avm_rdata` in DATA_W: downstream read data.
- `avm_wait_req` in 1: downstream stall.
- `grant` out NUM_CH: one-hot current owner; 0 when idle.
- `timeout` out 1: one-cycle pulse on abort.

## Operation
- The FSM has two states, IDLE and BUSY.
- **Request:** channel i requests when `ch_rd[i]|ch_wr[i]`. rd and wr together is illegal; both strobes pass through unchanged.
- **IDLE:** if any request exists, select the winner, register `grant` and go to BUSY. Otherwise stay in IDLE.
- **BUSY:**
  - The downstream bus carries the granted channel's addr, wdata, rd and wr.
  - `ch_wait_req[g]` = `avm_wait_req`, and `ch_rdata[g]` = `avm_rdata`, both combinational.
  - On `avm_wait_req`=0 the transfer completes. Go to IDLE and clear `grant`.
- **Non-granted channels:** `ch_wait_req`=1 at all times. `ch_rdata` = `avm_rdata` for every channel, but is only meaningful to the owner.
- **Idle bus:** `avm_rd`=`avm_wr`=0. `avm_addr` and `avm_wdata` hold their last value.
- **ARB_RR:** search from `last+1` upward, modulo NUM_CH. Update `last` to the winner when the grant is issued. Reset value of `last` is NUM_CH-1, so channel 0 wins first.
- **ARB_FIXED:** the lowest index wins. `last` is unused.
- **Withdrawal:** if the granted channel drops rd and wr while BUSY (a protocol violation), downstream strobes go low in that same cycle and the FSM returns to IDLE next cycle. No timeout pulse is raised.
- **Timeout:**
  - A stall counter (width `$clog2(MAX_WAIT+1)`) counts BUSY cycles with `avm_wait_req`=1.
  - When it reaches MAX_WAIT:
    - pulse `timeout` next cycle;
    - force `ch_wait_req[g]`=0 for one cycle with `ch_rdata[g]`=0, so the master unblocks;
    - drop the downstream strobes;
    - return to IDLE.
  - The counter clears on each new grant.
- **Reset:** all outputs take their reset values immediately, including during a transfer. Reset values: state IDLE, `grant`=0, `avm_rd`=`avm_wr`=0, `avm_addr`=`avm_wdata`=0, all `ch_wait_req`=1, `timeout`=0, counter 0.

## Timing
- Arbitration takes 1 cycle: a request in cycle N is driven downstream in cycle N+1.
- A zero-wait transfer completes in N+1. The owner sees `ch_wait_req`=0 in N+1.
- Minimum of 2 cycles per transfer, i.e. a 1-cycle IDLE bubble between grants. Peak throughput is 50 %.
- Worst-case latency for a steadily requesting channel in RR mode is (NUM_CH-1) transfers.
- Fixed mode may starve high indices; this is accepted.
- A timeout abort occurs MAX_WAIT+1 cycles after the grant at the earliest.
- Requests arriving during BUSY are only sampled in IDLE.

## Structure
- Add to `risc_pack`:
  - `arb_state_t` enum (`ARB_IDLE`, `ARB_BUSY`);
  - constants `ARB_RR`=0 and `ARB_FIXED`=1.
- Sub-module `qrisc32_rr_picker`: combinational. Inputs are a request vector and a start pointer; output is a one-hot winner. Fixed mode uses start pointer 0 with wrap disabled.
- The top-level wrapper later instantiates this block with NUM_CH=3. Channel mapping: ch0 = instructions, ch1 = data read, ch2 = data write.

## Test plan
- **Reset, then single request:** ch1 rd to addr 0x100 with `avm_wait_req`=0 and `avm_rdata`=0xDEADBEEF. Require `grant`=3'b010 in cycle N+1, `ch_wait_req[1]`=0, `ch_rdata[1]`=0xDEADBEEF, and `grant`=0 in N+2.
- **RR fairness:** all three channels request continuously with zero wait. Grants follow ch0, ch1, ch2, ch0…, one every 2 cycles.
- **Fixed mode:** ch0 and ch2 request continuously. Only ch0 is granted, and `ch_wait_req[2]` stays 1.
- **Stall:** ch2 writes 0x55AA to 0x40 with `avm_wait_req` high for 5 cycles. `avm_wr`, `avm_addr` and `avm_wdata` stay stable, `ch_wait_req[2]` mirrors the stall, and completion happens in the cycle wait drops.
- **Timeout:** MAX_WAIT=4 and `avm_wait_req` stuck at 1. `timeout` pulses once, `ch_wait_req[g]`=0 for one cycle with rdata 0, and the next requester is granted after.
- **Reset mid-transfer:** assert `reset` during BUSY. In the same cycle `avm_rd`/`avm_wr`=0, `grant`=0 and all `ch_wait_req`=1. After release, ch0 wins first.
